// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, taken-branch
// flushes and multdiv holds, plus stall/flush event counters for performance debug.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fd_IR,
  input  logic [31:0]      dx_IR,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_nop,
  output logic             dx_we,
  output logic             dx_nop,
  output logic             xm_we,
  output logic             xm_nop,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t state, next_state;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_is_mul, dx_is_div, dx_is_load;
  logic       reads_rd, reads_rs, reads_rt;
  logic       load_use;
  logic       flush_evt;
  logic       unused_bits;

  assign fd_op  = fd_IR[31:27];
  assign fd_rd  = fd_IR[26:22];
  assign fd_rs  = fd_IR[21:17];
  assign fd_rt  = fd_IR[16:12];
  assign dx_op  = dx_IR[31:27];
  assign dx_rd  = dx_IR[26:22];
  assign dx_alu = dx_IR[6:2];

  assign unused_bits = ^{fd_IR[11:0], dx_IR[21:7], dx_IR[1:0]};

  assign dx_is_mul  = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div  = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign dx_is_load = (dx_op == OP_LW) && (dx_rd != 5'd0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    reads_rd = 1'b0;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    unique case (fd_op)
      OP_RTYPE:              begin reads_rs = 1'b1; reads_rt = 1'b1; end
      OP_ADDI, OP_LW:        reads_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin reads_rd = 1'b1; reads_rs = 1'b1; end
      OP_JR:                 reads_rd = 1'b1;
      default: ;
    endcase
  end

  assign load_use = dx_is_load && ((reads_rd && (fd_rd == dx_rd)) ||
                                   (reads_rs && (fd_rs == dx_rd)) ||
                                   (reads_rt && (fd_rt == dx_rd)));

  always_comb begin
    next_state   = state;
    pc_we        = 1'b1;
    fd_we        = 1'b1;
    dx_we        = 1'b1;
    xm_we        = 1'b1;
    fd_nop       = 1'b0;
    dx_nop       = 1'b0;
    xm_nop       = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    flush_evt    = 1'b0;
    // Reset overrides everything so the pipeline free-runs while held.
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (dx_is_mul || dx_is_div) begin
            md_ctrl_MULT = dx_is_mul;
            md_ctrl_DIV  = dx_is_div;
            pc_we        = 1'b0;
            fd_we        = 1'b0;
            dx_we        = 1'b0;
            xm_nop       = 1'b1;
            next_state   = MD_WAIT;
          end else if (branch_taken) begin
            fd_nop    = 1'b1;
            dx_nop    = 1'b1;
            flush_evt = 1'b1;
          end else if (load_use) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            dx_nop = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_ready) begin
            next_state = RUN;
          end else begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            dx_we  = 1'b0;
            xm_nop = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= next_state;
      if (!pc_we)    stall_count <= stall_count + 1'b1;
      if (flush_evt) flush_count <= flush_count + 1'b1;
    end
  end

  assign md_busy = (state == MD_WAIT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a rule-level model checked every cycle, plus
// hand-computed literal expectations for load-use, flush, multdiv, reset and wrap.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fd_IR, dx_IR;
  logic        branch_taken, md_ready;

  logic        pc_we, fd_we, fd_nop, dx_we, dx_nop, xm_we, xm_nop;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_busy;
  logic [31:0] stall_count, flush_count;

  logic        pc_we4, fd_we4, fd_nop4, dx_we4, dx_nop4, xm_we4, xm_nop4;
  logic        mul4, div4, busy4;
  logic [3:0]  stall_count4, flush_count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .fd_IR(fd_IR), .dx_IR(dx_IR),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_we(pc_we), .fd_we(fd_we), .fd_nop(fd_nop), .dx_we(dx_we), .dx_nop(dx_nop),
    .xm_we(xm_we), .xm_nop(xm_nop), .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_busy(md_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .fd_IR(fd_IR), .dx_IR(dx_IR),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_we(pc_we4), .fd_we(fd_we4), .fd_nop(fd_nop4), .dx_we(dx_we4), .dx_nop(dx_nop4),
    .xm_we(xm_we4), .xm_nop(xm_nop4), .md_ctrl_MULT(mul4), .md_ctrl_DIV(div4),
    .md_busy(busy4), .stall_count(stall_count4), .flush_count(flush_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rd, rs, rt, alu);
    logic [4:0] f_rd, f_rs, f_rt, f_alu;
    f_rd = 5'(rd); f_rs = 5'(rs); f_rt = 5'(rt); f_alu = 5'(alu);
    return {5'd0, f_rd, f_rs, f_rt, 5'd0, f_alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input int op, rd, rs);
    logic [4:0] f_op, f_rd, f_rs;
    f_op = 5'(op); f_rd = 5'(rd); f_rs = 5'(rs);
    return {f_op, f_rd, f_rs, 17'd4};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit pc_we, fd_we, fd_nop, dx_we, dx_nop, xm_we, xm_nop, mul, div;
  } exp_t;

  // Set of architectural registers that the F/D instruction reads.
  function automatic bit [31:0] read_set(input logic [31:0] ir);
    bit [31:0] s = '0;
    int op = int'(ir[31:27]);
    int rd = int'(ir[26:22]);
    int rs = int'(ir[21:17]);
    int rt = int'(ir[16:12]);
    if (op == 0)                           begin s[rs] = 1; s[rt] = 1; end
    else if (op == 5 || op == 8)           s[rs] = 1;
    else if (op == 7 || op == 2 || op == 6) begin s[rd] = 1; s[rs] = 1; end
    else if (op == 4)                      s[rd] = 1;
    return s;
  endfunction

  function automatic exp_t predict(input bit waiting, input bit rst, input logic [31:0] fd,
                                   input logic [31:0] dx, input bit bt, input bit mdr);
    exp_t e;
    int   dx_op  = int'(dx[31:27]);
    int   dx_rd  = int'(dx[26:22]);
    int   dx_alu = int'(dx[6:2]);
    bit   is_md  = (dx_op == 0) && (dx_alu == 6 || dx_alu == 7);
    bit [31:0] rs_set = read_set(fd);
    bit   hazard = (dx_op == 8) && (dx_rd != 0) && rs_set[dx_rd];
    e = '{pc_we: 1, fd_we: 1, fd_nop: 0, dx_we: 1, dx_nop: 0, xm_we: 1, xm_nop: 0, mul: 0, div: 0};
    if (rst) return e;
    if (waiting) begin
      if (!mdr) begin e.pc_we = 0; e.fd_we = 0; e.dx_we = 0; e.xm_nop = 1; end
    end else if (is_md) begin
      e.pc_we = 0; e.fd_we = 0; e.dx_we = 0; e.xm_nop = 1;
      e.mul = (dx_alu == 6);
      e.div = (dx_alu == 7);
    end else if (bt) begin
      e.fd_nop = 1; e.dx_nop = 1;
    end else if (hazard) begin
      e.pc_we = 0; e.fd_we = 0; e.dx_nop = 1;
    end
    return e;
  endfunction

  bit          m_wait;
  int unsigned m_stall, m_flush;

  always @(posedge clk or posedge reset) begin
    exp_t e;
    if (reset) begin
      m_wait  <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      e = predict(m_wait, 1'b0, fd_IR, dx_IR, branch_taken, md_ready);
      m_wait <= m_wait ? !md_ready : (e.mul || e.div);
      if (!e.pc_we)  m_stall <= m_stall + 1;
      if (e.fd_nop)  m_flush <= m_flush + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = predict(m_wait, reset, fd_IR, dx_IR, branch_taken, md_ready);
    check("pc_we", 32'(pc_we), 32'(e.pc_we));
    check("fd_we", 32'(fd_we), 32'(e.fd_we));
    check("fd_nop", 32'(fd_nop), 32'(e.fd_nop));
    check("dx_we", 32'(dx_we), 32'(e.dx_we));
    check("dx_nop", 32'(dx_nop), 32'(e.dx_nop));
    check("xm_we", 32'(xm_we), 32'(e.xm_we));
    check("xm_nop", 32'(xm_nop), 32'(e.xm_nop));
    check("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(e.mul));
    check("md_ctrl_DIV", 32'(md_ctrl_DIV), 32'(e.div));
    check("md_busy", 32'(md_busy), 32'(m_wait));
    check("stall_count", stall_count, m_stall);
    check("flush_count", flush_count, m_flush);
    check("stall_count4", 32'(stall_count4), m_stall % 16);
    check("flush_count4", 32'(flush_count4), m_flush % 16);
  end

  // ---------------- directed stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] fd, input logic [31:0] dx, input bit bt, input bit mdr);
    fd_IR = fd; dx_IR = dx; branch_taken = bt; md_ready = mdr;
  endtask

  logic [31:0] lw3, lw0, add_5_3_4, add_5_0_4, mul_i, div_a, div_b;
  int busy_cycles, mul_pulses, div_pulses, any_pulses;

  initial begin
    lw3       = i_type(8, 3, 1);
    lw0       = i_type(8, 0, 1);
    add_5_3_4 = r_type(5, 3, 4, 0);
    add_5_0_4 = r_type(5, 0, 4, 0);
    mul_i     = r_type(1, 2, 3, 6);
    div_a     = r_type(1, 2, 3, 7);
    div_b     = r_type(4, 5, 6, 7);

    reset = 1'b1;
    set_in(32'd0, mul_i, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("reset_pc_we", 32'(pc_we), 32'd1);
    check("reset_no_mult", 32'(md_ctrl_MULT), 32'd0);
    check("reset_busy", 32'(md_busy), 32'd0);
    set_in(32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    cycle();
    cycle();

    // Load-use: exactly one bubble, then the nop in D/X clears the hazard.
    set_in(add_5_3_4, lw3, 1'b0, 1'b0); #2;
    check("lu_we", {29'd0, pc_we, fd_we, dx_nop}, 32'b001);
    cycle();
    set_in(add_5_3_4, 32'd0, 1'b0, 1'b0); #2;
    check("lu_cleared", 32'(pc_we), 32'd1);
    check("lu_stall_count", stall_count, 32'd1);
    cycle();
    set_in(add_5_0_4, lw0, 1'b0, 1'b0); #2;
    check("lu_rd0", 32'(pc_we), 32'd1);
    cycle();

    // Read-set coverage: sw and jr read rd, addi only reads rs.
    set_in(i_type(7, 3, 2), lw3, 1'b0, 1'b0); cycle();
    set_in(i_type(4, 3, 0), lw3, 1'b0, 1'b0); cycle();
    set_in(i_type(5, 3, 1), lw3, 1'b0, 1'b0); #2;
    check("addi_rd_not_read", 32'(pc_we), 32'd1);
    cycle();

    // Taken branch, then taken branch together with a load-use hazard.
    set_in(32'd0, 32'd0, 1'b1, 1'b0); #2;
    check("br_ctrl", {29'd0, fd_nop, dx_nop, pc_we}, 32'b111);
    cycle();
    set_in(32'd0, 32'd0, 1'b0, 1'b0); #2;
    check("br_flush_count", flush_count, 32'd1);
    cycle();
    set_in(add_5_3_4, lw3, 1'b1, 1'b0); #2;
    check("br_over_lu", {30'd0, pc_we, fd_nop}, 32'b11);
    cycle();
    set_in(32'd0, 32'd0, 1'b0, 1'b0); #2;
    check("br_flush_count2", flush_count, 32'd2);
    cycle();

    // Clear counters, then a multiply with md_ready 17 cycles after start.
    reset = 1'b1; #2; reset = 1'b0;
    cycle();
    busy_cycles = 0; mul_pulses = 0;
    for (int i = 0; i < 18; i++) begin
      set_in(r_type(6, 1, 2, 0), mul_i, 1'b0, i == 17); #2;
      if (md_busy) busy_cycles++;
      if (md_ctrl_MULT) mul_pulses++;
      if (i == 5) check("mul_xm_nop", 32'(xm_nop), 32'd1);
      if (i == 17) begin
        check("mul_ready_stall", stall_count, 32'd17);
        check("mul_wrap4", 32'(stall_count4), 32'd1);
        check("mul_ready_we", {28'd0, pc_we, fd_we, dx_we, xm_we}, 32'hf);
      end
      cycle();
    end
    check("mul_busy_cycles", busy_cycles, 32'd17);
    check("mul_pulses", mul_pulses, 32'd1);

    // Back-to-back divides: the second start is in the first RUN cycle after ready.
    div_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(32'd0, div_a, 1'b0, i == 4); #2;
      if (md_ctrl_DIV) div_pulses++;
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(32'd0, div_b, 1'b0, i == 3); #2;
      if (md_ctrl_DIV) div_pulses++;
      if (i == 0) check("div2_immediate", 32'(md_ctrl_DIV), 32'd1);
      cycle();
    end
    check("div_pulses", div_pulses, 32'd2);
    set_in(32'd0, 32'd0, 1'b0, 1'b1); #2;
    check("ready_in_run", 32'(pc_we), 32'd1);
    cycle();
    set_in(32'd0, 32'd0, 1'b0, 1'b0); #2;
    check("ready_in_run_busy", 32'(md_busy), 32'd0);
    cycle();

    // Asynchronous reset five cycles into MD_WAIT.
    set_in(32'd0, mul_i, 1'b0, 1'b0);
    repeat (6) cycle();
    #2;
    check("pre_reset_busy", 32'(md_busy), 32'd1);
    reset = 1'b1; #1;
    check("async_busy", 32'(md_busy), 32'd0);
    check("async_stall", stall_count, 32'd0);
    check("async_flush", flush_count, 32'd0);
    check("async_we", {28'd0, pc_we, fd_we, dx_we, xm_we}, 32'hf);
    cycle(); #2;
    check("reset_hold_no_mult", 32'(md_ctrl_MULT), 32'd0);
    set_in(32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    any_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); #2;
      if (md_ctrl_MULT || md_ctrl_DIV) any_pulses++;
    end
    check("post_reset_no_start", any_pulses, 32'd0);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush sequencer for the five-stage pipeline. It drives the write-enable and bubble-insert controls of the F/D, D/X and X/M pipeline registers and the PC register. It detects load-use hazards and taken branches/jumps, and holds the pipeline while the multi-cycle multiplier/divider runs. It also keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 32, width of the stall_count and flush_count counters

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- fd_IR  in  32  instruction currently held in F/D
- dx_IR  in  32  instruction currently held in D/X
- branch_taken  in  1  execute stage resolved a taken bne/blt or j/jal/jr this cycle
- md_ready  in  1  multdiv result valid (single-cycle pulse)
- pc_we  out  1  PC register enable
- fd_we  out  1  F/D enable
- fd_nop  out  1  load nop (32'b0) into F/D on this edge
- dx_we  out  1  D/X enable
- dx_nop  out  1  load nop into D/X on this edge
- xm_we  out  1  X/M enable
- xm_nop  out  1  load nop into X/M on this edge
- md_ctrl_MULT  out  1  one-cycle multdiv start, multiply
- md_ctrl_DIV  out  1  one-cycle multdiv start, divide
- md_busy  out  1  state is MD_WAIT
- stall_count  out  CNT_W  cycles with pc_we=0
- flush_count  out  CNT_W  taken-branch flush events

## Operation
- Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- dx_IR is a multdiv op when opcode=00000 and ALU op is 00110 (mul) or 00111 (div).
- dx_IR is a load when opcode=01000 and rd≠0.
- Registers read by fd_IR:
  - R-type (00000): rs, rt.
  - addi (00101) and lw (01000): rs.
  - sw (00111), bne (00010), blt (00110): rd, rs.
  - jr (00100): rd.
  - All other opcodes read nothing.
- Load-use hazard: dx_IR is a load and its rd equals any register read by fd_IR.
- States: RUN, MD_WAIT. Reset state is RUN.
- RUN, priority order (highest first):
  1. Multdiv op in dx_IR:
     - Pulse md_ctrl_MULT or md_ctrl_DIV for this cycle only.
     - pc_we=fd_we=dx_we=0; xm_we=1, xm_nop=1.
     - Next state MD_WAIT.
  2. branch_taken:
     - pc_we=1, fd_nop=1, dx_nop=1, xm_we=1.
     - flush_count += 1.
  3. Load-use hazard:
     - pc_we=0, fd_we=0, dx_nop=1, xm_we=1.
  4. Otherwise: all *_we=1, all *_nop=0.
- MD_WAIT, md_ready=0:
  - pc_we=fd_we=dx_we=0; xm_we=1, xm_nop=1.
  - md_ctrl_* = 0.
- MD_WAIT, md_ready=1:
  - All *_we=1, all *_nop=0; X/M captures the multdiv result.
  - D/X advances to a new instruction. No restart occurs, because the start condition is evaluated only in RUN.
  - Next state RUN.
- md_ready seen in RUN is ignored.
- Whenever a *_nop output is 1, the matching *_we is also 1.
- stall_count += 1 on every edge where pc_we=0 and reset is low.
- Both counters wrap modulo 2^CNT_W.

## Timing
- While reset is high:
  - State is RUN; counters are 0.
  - Outputs are forced to pc_we=fd_we=dx_we=xm_we=1, all *_nop=0, md_ctrl_*=0, md_busy=0.
  - Reset asserted in MD_WAIT returns to RUN immediately; no further start pulse is issued.
- All outputs except the counters and md_busy are combinational from state and inputs (zero latency).
- md_busy and the counters are registered.
- Multdiv start is sampled by the multdiv unit on the same edge where state moves RUN→MD_WAIT. Operands stay stable because D/X is frozen.
- Back-to-back mul then div: the second start occurs in the first RUN cycle after md_ready, with no idle cycle in between.
- Load-use costs exactly one bubble. The next cycle dx_IR is a nop, so the hazard clears.

## Test plan
- Load-use:
  - Stimulus: dx_IR = lw $3 (rd=3), fd_IR = add $5,$3,$4.
  - Required: pc_we=0, fd_we=0, dx_nop=1 for exactly one cycle; stall_count=1.
  - Repeat with rd=0: no stall.
- Taken branch:
  - Stimulus: branch_taken=1 for one cycle.
  - Required: fd_nop=1, dx_nop=1, pc_we=1; flush_count 0→1.
  - Also drive branch_taken=1 together with a load-use condition: flush wins, pc_we=1.
- Multiply:
  - Stimulus: dx_IR = mul (ALU op 00110); md_ready pulsed 17 cycles later.
  - Required: md_ctrl_MULT high for one cycle only; md_busy=1 for 17 cycles; xm_nop=1 during the wait.
  - Required: stall_count=17 when the ready cycle is reached; all enables 1 on the ready cycle.
- Back-to-back div:
  - Stimulus: div followed by another div.
  - Required: two separate md_ctrl_DIV pulses, each one cycle; md_ready arriving while in RUN has no effect.
- Reset mid-wait:
  - Stimulus: assert reset asynchronously 5 cycles into MD_WAIT.
  - Required: md_busy=0, counters=0, all *_we=1 without waiting for a clock edge.
  - After release with dx_IR = nop, no md_ctrl pulse.
- Counter wrap:
  - Stimulus: CNT_W=4, hold a stall for 17 cycles.
  - Required: stall_count wraps to 1.
